// File: rtl/rv32i_fetch_pkg.sv
// rv32i_fetch_pkg: shared types and constants for the instruction-fetch stage.
// Contents: fetch FSM encodings, NOP encoding, PC increment, skid-buffer packet type.
// Used by rv32i_fetch and rv32i_fetch_skid.
package rv32i_fetch_pkg;

  // Fetch FSM state encodings
  typedef enum logic [1:0] {
    FETCH_S_IDLE    = 2'd0,
    FETCH_S_REQ     = 2'd1,
    FETCH_S_DISCARD = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_INC   = 32'd4;

  // Instruction plus the PC it was fetched from
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_pkt_t;

  // Sequential PC; wraps naturally at 2^32
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/rv32i_fetch_skid.sv
// rv32i_fetch_skid: 1-entry buffer holding an instruction that arrived while decode was stalled.
// Ports: i_wr/i_pkt load the entry, i_rd empties it, i_flush drops it; o_full/o_pkt expose it.
// Flush has priority over write, write over read.
module rv32i_fetch_skid
  import rv32i_fetch_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr,
  input  logic       i_rd,
  input  logic       i_flush,
  input  fetch_pkt_t i_pkt,
  output logic       o_full,
  output fetch_pkt_t o_pkt
);

  logic       r_full;
  fetch_pkt_t r_pkt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= 1'b0;
      r_pkt  <= '0;
    end else begin
      if (i_flush) begin
        r_full <= 1'b0;
      end else if (i_wr) begin
        r_full <= 1'b1;
        r_pkt  <= i_pkt;
      end else if (i_rd) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_full = r_full;
  assign o_pkt  = r_pkt;

endmodule

// File: rtl/rv32i_fetch.sv
// rv32i_fetch: instruction-fetch stage; owns the PC, reads imem via req/ack, feeds decode.
// Ports: imem req/addr/ack/data; o_inst/o_pc/o_ce to decode; stall/flush and ALU/WB redirects in.
// Optional macro RV32I_FETCH_SKID_EN adds a 1-entry skid buffer so requests are not gated by stall.
module rv32i_fetch
  import rv32i_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_ce,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_alu_change_pc,
  input  logic [31:0] i_alu_next_pc,
  input  logic        i_wb_change_pc,
  input  logic [31:0] i_wb_next_pc
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_disc_addr, w_disc_addr_nxt;
  logic [31:0]  r_inst, w_inst_nxt;
  logic [31:0]  r_opc, w_opc_nxt;
  logic         r_ce, w_ce_nxt;
  logic         w_req, w_ack;
  logic         w_req_gate;
  logic         w_redirect;
  logic [31:0]  w_target;

  // Writeback (trap/mret) outranks ALU (branch/jump)
  assign w_redirect = i_wb_change_pc | i_alu_change_pc;
  assign w_target   = i_wb_change_pc ? i_wb_next_pc : i_alu_next_pc;

`ifdef RV32I_FETCH_SKID_EN
  logic       w_skid_wr, w_skid_rd, w_skid_flush, w_skid_full;
  fetch_pkt_t w_skid_in, w_skid_out;

  assign w_skid_in    = '{inst: i_imem_data, pc: r_pc};
  assign w_skid_flush = w_redirect | (i_flush & ~i_stall);
  // Stall no longer blocks the request; only a full buffer does
  assign w_req_gate   = ~w_skid_full;

  rv32i_fetch_skid u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr    (w_skid_wr),
    .i_rd    (w_skid_rd),
    .i_flush (w_skid_flush),
    .i_pkt   (w_skid_in),
    .o_full  (w_skid_full),
    .o_pkt   (w_skid_out)
  );
`else
  // Without a buffer there is nowhere to put an ack during stall
  assign w_req_gate = ~i_stall;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= FETCH_S_IDLE;
      r_pc        <= PC_RESET;
      r_disc_addr <= '0;
      r_inst      <= NOP_INST;
      r_opc       <= '0;
      r_ce        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_disc_addr <= w_disc_addr_nxt;
      r_inst      <= w_inst_nxt;
      r_opc       <= w_opc_nxt;
      r_ce        <= w_ce_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_disc_addr_nxt = r_disc_addr;
    w_inst_nxt      = r_inst;
    w_opc_nxt       = r_opc;
    w_ce_nxt        = r_ce;
    w_req           = 1'b0;
    w_ack           = 1'b0;
`ifdef RV32I_FETCH_SKID_EN
    w_skid_wr       = 1'b0;
    w_skid_rd       = 1'b0;
`endif
    case (r_state)
      FETCH_S_IDLE: begin
        w_state_nxt = FETCH_S_REQ;
        if (w_redirect) begin
          w_pc_nxt = w_target;
          w_ce_nxt = 1'b0;
        end
      end

      FETCH_S_REQ: begin
        w_req = w_req_gate;
        w_ack = w_req & i_imem_ack;
        if (w_redirect) begin
          // Redirect beats stall, flush and any ack this cycle
          w_pc_nxt = w_target;
          w_ce_nxt = 1'b0;
          if (w_req && !i_imem_ack) begin
            // Memory still owes us the old word; swallow it first
            w_state_nxt     = FETCH_S_DISCARD;
            w_disc_addr_nxt = r_pc;
          end
        end else if (i_stall) begin
          // Decode outputs hold; flush waits for stall release
`ifdef RV32I_FETCH_SKID_EN
          if (w_ack) begin
            w_skid_wr = 1'b1;
            w_pc_nxt  = pc_next(r_pc);
          end
`endif
        end else if (i_flush) begin
          // Bubble; ack dropped without advancing, so the word is refetched
          w_ce_nxt = 1'b0;
        end
`ifdef RV32I_FETCH_SKID_EN
        else if (w_skid_full) begin
          w_skid_rd  = 1'b1;
          w_inst_nxt = w_skid_out.inst;
          w_opc_nxt  = w_skid_out.pc;
          w_ce_nxt   = 1'b1;
        end
`endif
        else if (w_ack) begin
          w_inst_nxt = i_imem_data;
          w_opc_nxt  = r_pc;
          w_ce_nxt   = 1'b1;
          w_pc_nxt   = pc_next(r_pc);
        end else begin
          w_ce_nxt = 1'b0;
        end
      end

      FETCH_S_DISCARD: begin
        // Keep the stale request up until memory answers, then drop the word
        w_req    = 1'b1;
        w_ce_nxt = 1'b0;
        if (w_redirect) begin
          w_pc_nxt = w_target;
        end
        if (i_imem_ack) begin
          w_state_nxt = FETCH_S_REQ;
        end
      end

      default: begin
        w_state_nxt = FETCH_S_IDLE;
      end
    endcase
  end

  assign o_imem_req  = w_req;
  assign o_imem_addr = (r_state == FETCH_S_DISCARD) ? r_disc_addr : r_pc;
  assign o_inst      = r_inst;
  assign o_pc        = r_opc;
  assign o_ce        = r_ce;

endmodule

// File: tb/tb_rv32i_fetch.sv
// tb_rv32i_fetch: directed, table-driven bench for rv32i_fetch with a variable-latency imem model.
// A second instance with PC_RESET=FFFF_FFF8 checks PC wrap-around.
// Skid-build expectations are selected with RV32I_FETCH_SKID_EN.
module tb_rv32i_fetch;

  typedef struct {
    logic        stall, flush, alu, wb;
    logic [31:0] alu_pc, wb_pc;
    logic        req;
    logic [31:0] addr;
    logic        ce;
    logic [31:0] pc;
  } vec_t;

  logic        clk, rst_n;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_data, inst, pc;
  logic        ce, stall, flush, alu_chg, wb_chg;
  logic [31:0] alu_pc, wb_pc;

  logic        req2, ce2;
  logic [31:0] addr2, data2, inst2, pc2;

  int tests = 0;
  int fails = 0;
  int lat   = 1;
  int cnt;

  rv32i_fetch u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ack(imem_ack), .i_imem_data(imem_data),
    .o_inst(inst), .o_pc(pc), .o_ce(ce),
    .i_stall(stall), .i_flush(flush),
    .i_alu_change_pc(alu_chg), .i_alu_next_pc(alu_pc),
    .i_wb_change_pc(wb_chg), .i_wb_next_pc(wb_pc)
  );

  rv32i_fetch #(.PC_RESET(32'hFFFF_FFF8)) u_dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(req2), .o_imem_addr(addr2),
    .i_imem_ack(req2), .i_imem_data(data2),
    .o_inst(inst2), .o_pc(pc2), .o_ce(ce2),
    .i_stall(1'b0), .i_flush(1'b0),
    .i_alu_change_pc(1'b0), .i_alu_next_pc(32'h0),
    .i_wb_change_pc(1'b0), .i_wb_next_pc(32'h0)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Memory answers once the request has been held for lat cycles
  assign imem_ack  = imem_req && (cnt >= lat - 1);
  assign imem_data = mem_word(imem_addr);
  assign data2     = mem_word(addr2);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= 0;
    else if (imem_req && !imem_ack) cnt <= cnt + 1;
    else                           cnt <= 0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic f, input logic a, input logic [31:0] apc,
                              input logic w, input logic [31:0] wpc, input logic r,
                              input logic [31:0] ad, input logic c, input logic [31:0] p);
    vec_t v;
    v.stall = s; v.flush = f; v.alu = a; v.alu_pc = apc; v.wb = w; v.wb_pc = wpc;
    v.req = r; v.addr = ad; v.ce = c; v.pc = p;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t        vq[$];
  logic [31:0] wrap_exp[3];

  initial begin
    bit found;
    rst_n = 1'b0; stall = 0; flush = 0; alu_chg = 0; wb_chg = 0; alu_pc = 0; wb_pc = 0;
    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0000_0000;

`ifndef RV32I_FETCH_SKID_EN
    //            stall flush alu alu_pc      wb  wb_pc       req addr        ce  pc
    vq.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 32'h0));
    vq.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,    1, 32'h0,    1, 32'h0));
    vq.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,    1, 32'h4,    1, 32'h4));
    vq.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,    1, 32'h8,    1, 32'h8));
    vq.push_back(mk(1, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    1, 32'h8));
    vq.push_back(mk(1, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    1, 32'h8));
    vq.push_back(mk(1, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    1, 32'h8));
    vq.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,    1, 32'hC,    1, 32'hC));
    vq.push_back(mk(0, 1, 0, 32'h0,    0, 32'h0,    1, 32'h10,   0, 32'hC));
    vq.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,    1, 32'h10,   1, 32'h10));
    vq.push_back(mk(1, 1, 0, 32'h0,    0, 32'h0,    0, 32'h0,    1, 32'h10));
    vq.push_back(mk(0, 0, 1, 32'h300,  1, 32'h200,  1, 32'h14,   0, 32'h10));
    vq.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,    1, 32'h200,  1, 32'h200));
    vq.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,    1, 32'h204,  1, 32'h204));
    vq.push_back(mk(1, 0, 1, 32'h40,   0, 32'h0,    0, 32'h0,    0, 32'h204));
    vq.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,    1, 32'h40,   1, 32'h40));
`else
    vq.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 32'h0));
    vq.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,    1, 32'h0,    1, 32'h0));
    vq.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,    1, 32'h4,    1, 32'h4));
    vq.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,    1, 32'h8,    1, 32'h8));
    vq.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,    1, 32'hC,    1, 32'hC));
    vq.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,    1, 32'h10,   1, 32'h10));
    vq.push_back(mk(1, 0, 0, 32'h0,    0, 32'h0,    1, 32'h14,   1, 32'h10));
    vq.push_back(mk(1, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    1, 32'h10));
    vq.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    1, 32'h14));
    vq.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,    1, 32'h18,   1, 32'h18));
`endif

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",  {31'h0, imem_req}, 32'h0);
    chk("rst_ce",   {31'h0, ce},       32'h0);
    chk("rst_pc",   pc,                32'h0);
    chk("rst_inst", inst,              32'h0000_0013);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      stall = vq[i].stall; flush = vq[i].flush;
      alu_chg = vq[i].alu; alu_pc = vq[i].alu_pc;
      wb_chg = vq[i].wb;   wb_pc = vq[i].wb_pc;
      #1;
      chk($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vq[i].req});
      if (vq[i].req) chk($sformatf("v%0d_addr", i), imem_addr, vq[i].addr);
      tick();
      chk($sformatf("v%0d_ce", i), {31'h0, ce}, {31'h0, vq[i].ce});
      chk($sformatf("v%0d_pc", i), pc, vq[i].pc);
      if (vq[i].ce) chk($sformatf("v%0d_inst", i), inst, mem_word(vq[i].pc));
      if (i >= 1 && i <= 3) begin
        chk($sformatf("wrap%0d_ce", i), {31'h0, ce2}, 32'h1);
        chk($sformatf("wrap%0d_pc", i), pc2, wrap_exp[i-1]);
        chk($sformatf("wrap%0d_inst", i), inst2, mem_word(wrap_exp[i-1]));
      end
    end
    stall = 0; flush = 0; alu_chg = 0; wb_chg = 0;

    // Redirect to 0x10, then slow memory; ALU redirect to 0x100 mid-request
    wb_chg = 1; wb_pc = 32'h10;
    tick();
    wb_chg = 0;
    chk("r10_ce", {31'h0, ce}, 32'h0);
    lat = 3;
    #1;
    chk("slow_addr", imem_addr, 32'h10);
    tick();
    chk("slow_bubble_ce", {31'h0, ce}, 32'h0);
    alu_chg = 1; alu_pc = 32'h100;
    #1;
    chk("slow_noack", {31'h0, imem_ack}, 32'h0);
    tick();
    alu_chg = 0;
    chk("redir_ce", {31'h0, ce}, 32'h0);
    #1;
    chk("disc_req",  {31'h0, imem_req}, 32'h1);
    chk("disc_addr", imem_addr, 32'h10);
    chk("disc_ack",  {31'h0, imem_ack}, 32'h1);
    tick();
    chk("disc_ce", {31'h0, ce}, 32'h0);
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      tick();
      if (ce) found = 1;
    end
    chk("redir_found", {31'h0, found}, 32'h1);
    chk("redir_pc",    pc,   32'h100);
    chk("redir_inst",  inst, mem_word(32'h100));

    // Reset while a request is outstanding takes effect immediately
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req",  {31'h0, imem_req}, 32'h0);
    chk("mid_rst_ce",   {31'h0, ce},       32'h0);
    chk("mid_rst_pc",   pc,                32'h0);
    chk("mid_rst_inst", inst,              32'h0000_0013);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
